// File: rtl/servant_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : servant_trace_pkg
// Description : Shared types and constants for the servant trace buffer:
//               capture FSM state encoding, filter mode codes, event bit
//               positions and the mode filter helper.
// Revision    : 1.0 - initial release
// ============================================================================
package servant_trace_pkg;

  // Capture FSM states; encoding is visible on o_state
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

  // Filter mode codes (code 3 behaves like ALL)
  localparam logic [1:0] MODE_ALL   = 2'd0;
  localparam logic [1:0] MODE_FLOW  = 2'd1;
  localparam logic [1:0] MODE_IRQ   = 2'd2;
  localparam logic [1:0] MODE_ALL_B = 2'd3;

  // Bit positions inside the 3-bit event vector {timer_irq, mret, jump}
  localparam int EVT_IRQ  = 2;
  localparam int EVT_MRET = 1;
  localparam int EVT_JUMP = 0;

  // Decide whether a bus sample carrying event flags evt is worth storing
  function automatic logic mode_pass(input logic [1:0] mode, input logic [2:0] evt);
    logic pass;
    pass = 1'b1;
    case (mode)
      MODE_FLOW: pass = (evt != 3'b000);
      MODE_IRQ:  pass = evt[EVT_IRQ] | evt[EVT_MRET];
      default:   pass = 1'b1;
    endcase
    return pass;
  endfunction

endpackage : servant_trace_pkg
`default_nettype wire

// File: rtl/servant_trace_ram.sv
`default_nettype none
// ============================================================================
// Module      : servant_trace_ram
// Description : Trace storage, DEPTH x WIDTH, synchronous write and
//               asynchronous read. Storage is not reset; validity is tracked
//               by the owning logic.
// Revision    : 1.0 - initial release
// ============================================================================
module servant_trace_ram #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 35,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    wadr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    radr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Store one entry per write strobe
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[wadr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[radr_i];

endmodule : servant_trace_ram
`default_nettype wire

// File: rtl/servant_trace_buf.sv
`default_nettype none
// ============================================================================
// Module      : servant_trace_buf
// Description : Circular trace capture of bus addresses and event strobes
//               with mode filtering, timer-IRQ trigger, post-trigger depth
//               and a freeze-then-drain readout port.
// Revision    : 1.0 - initial release
// ============================================================================
module servant_trace_buf
  import servant_trace_pkg::*;
#(
  parameter int ADR_W     = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input  logic                     wb_clk,
  input  logic                     wb_rst_n,
  input  logic [ADR_W-1:0]         i_pc_adr,
  input  logic                     i_pc_vld,
  input  logic [2:0]               i_evt,
  input  logic [1:0]               i_mode,
  input  logic                     i_arm,
  input  logic                     i_rd_en,
  output logic [ADR_W+2:0]         o_rd_data,
  output logic                     o_rd_vld,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [1:0]               o_state,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = ADR_W + 3;
  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [CW-1:0] POST_TRIG_C = CW'(POST_TRIG);

  trace_state_e   state_q, state_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [CW-1:0]  post_cnt_q, post_cnt_d;
  logic [2:0]     sticky_q, sticky_d;
  logic [1:0]     mode_q, mode_d;
  logic           overflow_q, overflow_d;
  logic           irq_prev_q;

  logic [2:0]     entry_evt;
  logic           trig_edge;
  logic           capture;
  logic           rd_vld;
  logic [DW-1:0]  ram_rdata;

  // Events seen since the last bus sample are folded into the next entry
  assign entry_evt = sticky_q | i_evt;
  assign trig_edge = i_evt[EVT_IRQ] & ~irq_prev_q;
  assign capture   = i_pc_vld & mode_pass(mode_q, entry_evt) &
                     ((state_q == ST_ARMED) || (state_q == ST_POST));
  assign rd_vld    = (state_q == ST_DONE) && (count_q != '0);

  // Next-state logic for the FSM, pointers, fill level and event tracking
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    post_cnt_d = post_cnt_q;
    mode_d     = mode_q;
    overflow_d = overflow_q;
    sticky_d   = i_pc_vld ? 3'b000 : (sticky_q | i_evt);

    if (capture) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (count_q == DEPTH_C) begin
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (i_arm) begin
          state_d    = ST_ARMED;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          count_d    = '0;
          post_cnt_d = '0;
          overflow_d = 1'b0;
          sticky_d   = 3'b000;
          mode_d     = i_mode;
        end
      end
      ST_ARMED: begin
        // A capture in the trigger cycle still belongs to pre-trigger history
        if (trig_edge) begin
          state_d = ST_POST;
        end
      end
      ST_POST: begin
        if (capture) begin
          post_cnt_d = post_cnt_q + 1'b1;
          if ((post_cnt_q + 1'b1) == POST_TRIG_C) begin
            state_d  = ST_DONE;
            // Oldest entry sits count positions behind the write pointer
            rd_ptr_d = wr_ptr_d - count_d[AW-1:0];
          end
        end
      end
      ST_DONE: begin
        if (i_arm) begin
          state_d    = ST_ARMED;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          count_d    = '0;
          post_cnt_d = '0;
          overflow_d = 1'b0;
          sticky_d   = 3'b000;
          mode_d     = i_mode;
        end else if (i_rd_en && rd_vld) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          count_d  = count_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      post_cnt_q <= '0;
      mode_q     <= MODE_ALL;
      overflow_q <= 1'b0;
      sticky_q   <= 3'b000;
      irq_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      post_cnt_q <= post_cnt_d;
      mode_q     <= mode_d;
      overflow_q <= overflow_d;
      sticky_q   <= sticky_d;
      irq_prev_q <= i_evt[EVT_IRQ];
    end
  end

  servant_trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (DW)
  ) u_ram (
    .clk_i   (wb_clk),
    .we_i    (capture),
    .wadr_i  (wr_ptr_q),
    .wdata_i ({entry_evt, i_pc_adr}),
    .radr_i  (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  // Read data is masked when nothing is valid so reset/idle outputs are zero
  assign o_rd_data  = rd_vld ? ram_rdata : '0;
  assign o_rd_vld   = rd_vld;
  assign o_count    = count_q;
  assign o_state    = state_q;
  assign o_overflow = overflow_q;

endmodule : servant_trace_buf
`default_nettype wire

// File: tb/tb_servant_trace_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_servant_trace_buf
// Description : Directed self-checking bench for servant_trace_buf.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_servant_trace_buf;

  localparam int ADR_W = 32;
  localparam int DEPTH = 16;
  localparam int PT    = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_adr;
  logic        pc_vld;
  logic [2:0]  evt;
  logic [1:0]  mode;
  logic        arm;
  logic        rd_en;
  logic [34:0] rd_data;
  logic        rd_vld;
  logic [4:0]  count;
  logic [1:0]  state;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  servant_trace_buf #(
    .ADR_W     (ADR_W),
    .DEPTH     (DEPTH),
    .POST_TRIG (PT)
  ) dut (
    .wb_clk     (clk),
    .wb_rst_n   (rst_n),
    .i_pc_adr   (pc_adr),
    .i_pc_vld   (pc_vld),
    .i_evt      (evt),
    .i_mode     (mode),
    .i_arm      (arm),
    .i_rd_en    (rd_en),
    .o_rd_data  (rd_data),
    .o_rd_vld   (rd_vld),
    .o_count    (count),
    .o_state    (state),
    .o_overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vld(input logic [31:0] a, input logic [2:0] e);
    pc_vld = 1'b1;
    pc_adr = a;
    evt    = e;
    tick();
    pc_vld = 1'b0;
    evt    = 3'b000;
  endtask

  task automatic pulse_evt(input logic [2:0] e);
    evt = e;
    tick();
    evt = 3'b000;
  endtask

  task automatic do_arm(input logic [1:0] m);
    mode = m;
    arm  = 1'b1;
    tick();
    arm  = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [34:0] exp);
    check_eq(tag, 64'(rd_data), 64'(exp));
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; pc_adr = '0; pc_vld = 1'b0; evt = 3'b000;
    mode = 2'd0; arm = 1'b0; rd_en = 1'b0;
    tick();
    tick();
    check_eq("rst_state", 64'(state), 64'd0);
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_rdvld", 64'(rd_vld), 64'd0);
    check_eq("rst_ovf",   64'(overflow), 64'd0);
    check_eq("rst_rdata", 64'(rd_data), 64'd0);
    rst_n = 1'b1;

    // IDLE ignores bus samples
    vld(32'h500, 3'b000);
    check_eq("idle_nocap", 64'(count), 64'd0);

    // ---- Mode ALL: 3 pre, irq edge, 8 post ----
    do_arm(2'd0);
    check_eq("a_armed", 64'(state), 64'd1);
    vld(32'h100, 3'b000);
    vld(32'h104, 3'b000);
    vld(32'h108, 3'b000);
    pulse_evt(3'b100);
    check_eq("a_post", 64'(state), 64'd2);
    for (int i = 0; i < PT; i++) begin
      if (i == PT - 1) check_eq("a_post_before_last", 64'(state), 64'd2);
      vld(32'h200 + 32'(i * 4), 3'b000);
    end
    check_eq("a_done",  64'(state), 64'd3);
    check_eq("a_count", 64'(count), 64'd11);
    check_eq("a_rdvld", 64'(rd_vld), 64'd1);
    pop_check("a_pop0", {3'b000, 32'h100});
    pop_check("a_pop1", {3'b000, 32'h104});
    pop_check("a_pop2", {3'b000, 32'h108});
    pop_check("a_pop3", {3'b100, 32'h200});
    for (int i = 1; i < PT; i++) begin
      pop_check("a_popn", {3'b000, 32'h200 + 32'(i * 4)});
    end
    check_eq("a_empty_count", 64'(count), 64'd0);
    check_eq("a_empty_rdvld", 64'(rd_vld), 64'd0);
    // Pop with nothing held must be ignored
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check_eq("a_pop0_count", 64'(count), 64'd0);
    check_eq("a_pop0_state", 64'(state), 64'd3);

    // ---- Overflow: 20 pre-trigger, trigger, 8 post ----
    do_arm(2'd0);
    check_eq("b_arm_count", 64'(count), 64'd0);
    for (int i = 0; i < 20; i++) begin
      vld(32'(i * 4), 3'b000);
      if (i == 15) begin
        check_eq("b_full_count", 64'(count), 64'd16);
        check_eq("b_full_noovf", 64'(overflow), 64'd0);
      end
    end
    check_eq("b_ovf", 64'(overflow), 64'd1);
    pulse_evt(3'b100);
    for (int i = 0; i < PT; i++) vld(32'h50 + 32'(i * 4), 3'b000);
    check_eq("b_done",   64'(state), 64'd3);
    check_eq("b_count",  64'(count), 64'd16);
    check_eq("b_ovf2",   64'(overflow), 64'd1);
    check_eq("b_first",  64'(rd_data), 64'({3'b000, 32'h30}));

    // ---- Mode FLOW, with i_mode changed after arm ----
    do_arm(2'd1);
    check_eq("c_arm_ovf", 64'(overflow), 64'd0);
    mode = 2'd0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) pulse_evt(3'b001);
      vld(32'h300 + 32'(i * 4), 3'b000);
    end
    check_eq("c_one_entry", 64'(count), 64'd1);
    pulse_evt(3'b100);
    check_eq("c_post", 64'(state), 64'd2);
    vld(32'h400, 3'b000);
    for (int i = 1; i < PT; i++) vld(32'h400 + 32'(i * 4), 3'b001);
    check_eq("c_done",  64'(state), 64'd3);
    check_eq("c_count", 64'(count), 64'd9);
    pop_check("c_pop0", {3'b001, 32'h30C});
    pop_check("c_pop1", {3'b100, 32'h400});
    pop_check("c_pop2", {3'b001, 32'h404});

    // ---- Irq rise in the same cycle as a capture ----
    do_arm(2'd0);
    vld(32'h200, 3'b100);
    check_eq("d_post",  64'(state), 64'd2);
    check_eq("d_count", 64'(count), 64'd1);
    for (int i = 1; i < PT; i++) vld(32'h600 + 32'(i * 4), 3'b000);
    check_eq("d_still_post", 64'(state), 64'd2);
    vld(32'h700, 3'b000);
    check_eq("d_done",  64'(state), 64'd3);
    check_eq("d_count9", 64'(count), 64'd9);
    check_eq("d_first", 64'(rd_data), 64'({3'b100, 32'h200}));

    // ---- Arm beats a same-cycle pop ----
    for (int i = 0; i < 6; i++) begin
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b0;
    check_eq("e_count3", 64'(count), 64'd3);
    arm = 1'b1; rd_en = 1'b1;
    tick();
    arm = 1'b0; rd_en = 1'b0;
    check_eq("e_armed", 64'(state), 64'd1);
    check_eq("e_count", 64'(count), 64'd0);
    check_eq("e_rdvld", 64'(rd_vld), 64'd0);

    // ---- Reset in the middle of POST ----
    vld(32'h800, 3'b000);
    vld(32'h804, 3'b000);
    pulse_evt(3'b100);
    vld(32'h808, 3'b000);
    vld(32'h80C, 3'b000);
    vld(32'h810, 3'b000);
    check_eq("f_post",  64'(state), 64'd2);
    check_eq("f_count", 64'(count), 64'd5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("f_state", 64'(state), 64'd0);
    check_eq("f_count0", 64'(count), 64'd0);
    check_eq("f_rdvld", 64'(rd_vld), 64'd0);
    check_eq("f_ovf",   64'(overflow), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_servant_trace_buf
`default_nettype wire
